// File: rtl/multi_cycle_controller_pkg.sv
// rtl/multi_cycle_controller_pkg.sv - shared encodings for the multi-cycle controller
package multi_cycle_controller_pkg;

  // Controller phases; every instruction starts in S_FETCH
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  // Instruction type lives in op[5:3]; op[2:0] is the function / ALU code
  localparam logic [2:0] TYPE_REG   = 3'b000;
  localparam logic [2:0] TYPE_IMM   = 3'b001;
  localparam logic [2:0] TYPE_SHIFT = 3'b100;
  localparam logic [2:0] TYPE_MEM   = 3'b101;
  localparam logic [2:0] TYPE_JCOND = 3'b110;
  localparam logic [2:0] TYPE_JMP   = 3'b111;

  // Function codes within the memory type
  localparam logic [2:0] LDM_FN = 3'b000;
  localparam logic [2:0] STM_FN = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;

  localparam logic [1:0] PC_SRC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_SRC_OFFSET = 2'b01;
  localparam logic [1:0] PC_SRC_CONST  = 2'b10;

  localparam logic [1:0] RF_IN_ALU   = 2'b00;
  localparam logic [1:0] RF_IN_MEM   = 2'b01;
  localparam logic [1:0] RF_IN_SHIFT = 2'b10;

  // One-hot opcode class bit positions
  localparam int CLS_JMP    = 0;
  localparam int CLS_JCOND  = 1;
  localparam int CLS_STM    = 2;
  localparam int CLS_LDM    = 3;
  localparam int CLS_MEMNOP = 4;
  localparam int CLS_SHIFT  = 5;
  localparam int CLS_IMM    = 6;
  localparam int CLS_REG    = 7;
  localparam int CLS_NOP    = 8;
  localparam int CLS_W      = 9;

  typedef logic [CLS_W-1:0] op_class_t;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - controller to datapath/memory signal bundle
interface multi_cycle_controller_if;
  logic [5:0] mem_rdata_op;
  logic       cond_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       IR_write;
  logic       PC_write;
  logic [1:0] PC_src;
  logic [2:0] ALU_op;
  logic       ALU_src;
  logic [1:0] RF_in_sel;
  logic       RF_write;
  logic       RF_dst_r2;
  logic       RF_rd2_rd;
  logic       instr_done;

  modport master (
    input  mem_rdata_op, cond_flag, mem_ready,
    output mem_req, mem_we, mem_addr_sel, IR_write, PC_write, PC_src,
           ALU_op, ALU_src, RF_in_sel, RF_write, RF_dst_r2, RF_rd2_rd, instr_done
  );

  modport slave (
    output mem_rdata_op, cond_flag, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, IR_write, PC_write, PC_src,
           ALU_op, ALU_src, RF_in_sel, RF_write, RF_dst_r2, RF_rd2_rd, instr_done
  );
endinterface

// File: rtl/multi_cycle_controller_opcode_decoder.sv
// rtl/multi_cycle_controller_opcode_decoder.sv - combinational opcode classifier
module opcode_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] op_i,
  output op_class_t  cls_o
);

  // Priority chain keeps the class one-hot even if type fields ever overlap
  always_comb begin
    cls_o = '0;
    if (op_i[5:3] == TYPE_JMP) begin
      cls_o[CLS_JMP] = 1'b1;
    end else if (op_i[5:3] == TYPE_JCOND) begin
      cls_o[CLS_JCOND] = 1'b1;
    end else if (op_i[5:3] == TYPE_MEM) begin
      if (op_i[2:0] == STM_FN)      cls_o[CLS_STM]    = 1'b1;
      else if (op_i[2:0] == LDM_FN) cls_o[CLS_LDM]    = 1'b1;
      else                          cls_o[CLS_MEMNOP] = 1'b1;
    end else if (op_i[5:3] == TYPE_SHIFT) begin
      cls_o[CLS_SHIFT] = 1'b1;
    end else if (op_i[5:3] == TYPE_IMM) begin
      cls_o[CLS_IMM] = 1'b1;
    end else if (op_i[5:3] == TYPE_REG) begin
      cls_o[CLS_REG] = 1'b1;
    end else begin
      cls_o[CLS_NOP] = 1'b1;
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - five-phase multi-cycle CPU control FSM
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  multi_cycle_controller_if.master ctl
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  op_class_t  cls;
  logic       is_mem;

  opcode_decoder u_opcode_decoder (
    .op_i  (op_q),
    .cls_o (cls)
  );

  assign is_mem = cls[CLS_STM] | cls[CLS_LDM] | cls[CLS_MEMNOP];

  // Phase and latched opcode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next phase and control outputs; rst masks every output so a held or
  // mid-instruction reset never leaks a memory request or register write
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    ctl.mem_req      = 1'b0;
    ctl.mem_we       = 1'b0;
    ctl.mem_addr_sel = 1'b0;
    ctl.IR_write     = 1'b0;
    ctl.PC_write     = 1'b0;
    ctl.PC_src       = PC_SRC_PLUS1;
    ctl.ALU_op       = '0;
    ctl.ALU_src      = 1'b0;
    ctl.RF_in_sel    = RF_IN_ALU;
    ctl.RF_write     = 1'b0;
    ctl.RF_dst_r2    = 1'b0;
    ctl.RF_rd2_rd    = 1'b0;
    ctl.instr_done   = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctl.mem_req = 1'b1;
          if (ctl.mem_ready) begin
            ctl.IR_write = 1'b1;
            op_d         = ctl.mem_rdata_op;
            state_d      = S_DECODE;
          end
        end

        S_DECODE: begin
          ctl.RF_rd2_rd = cls[CLS_STM];
          state_d       = S_EXECUTE;
        end

        S_EXECUTE: begin
          if (cls[CLS_JMP]) begin
            ctl.PC_write   = 1'b1;
            ctl.PC_src     = PC_SRC_CONST;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end else if (cls[CLS_JCOND]) begin
            ctl.PC_write   = 1'b1;
            ctl.PC_src     = ctl.cond_flag ? PC_SRC_OFFSET : PC_SRC_PLUS1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end else if (is_mem) begin
            // Effective address is base register plus constant offset
            ctl.ALU_op  = ALU_ADD;
            ctl.ALU_src = 1'b1;
            state_d     = S_MEM;
          end else if (cls[CLS_SHIFT]) begin
            state_d = S_WRITEBACK;
          end else if (cls[CLS_IMM]) begin
            ctl.ALU_op  = op_q[2:0];
            ctl.ALU_src = 1'b1;
            state_d     = S_WRITEBACK;
          end else if (cls[CLS_REG]) begin
            ctl.ALU_op = op_q[2:0];
            state_d    = S_WRITEBACK;
          end else begin
            ctl.PC_write   = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
        end

        S_MEM: begin
          ctl.mem_req      = 1'b1;
          ctl.mem_addr_sel = 1'b1;
          ctl.ALU_src      = 1'b1;
          ctl.mem_we       = cls[CLS_STM];
          ctl.RF_rd2_rd    = cls[CLS_STM];
          if (ctl.mem_ready) begin
            if (cls[CLS_LDM]) begin
              state_d = S_WRITEBACK;
            end else begin
              ctl.PC_write   = 1'b1;
              ctl.instr_done = 1'b1;
              state_d        = S_FETCH;
            end
          end
        end

        S_WRITEBACK: begin
          ctl.RF_write   = 1'b1;
          ctl.PC_write   = 1'b1;
          ctl.instr_done = 1'b1;
          if (cls[CLS_SHIFT]) begin
            ctl.RF_in_sel = RF_IN_SHIFT;
          end else if (cls[CLS_LDM]) begin
            ctl.RF_in_sel = RF_IN_MEM;
            ctl.RF_dst_r2 = 1'b1;
          end
          state_d = S_FETCH;
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - directed self-checking bench for multi_cycle_controller
module tb_multi_cycle_controller;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  multi_cycle_controller_if bus ();

  multi_cycle_controller dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector bit layout:
  // [16]req [15]we [14]asel [13]irw [12]pcw [11:10]pc_src [9:7]alu_op
  // [6]alu_src [5:4]rf_in [3]rf_write [2]dst_r2 [1]rd2_rd [0]done
  localparam logic [16:0] REQ  = 17'h10000;
  localparam logic [16:0] WE   = 17'h08000;
  localparam logic [16:0] ASEL = 17'h04000;
  localparam logic [16:0] IRW  = 17'h02000;
  localparam logic [16:0] PCW  = 17'h01000;
  localparam logic [16:0] ASRC = 17'h00040;
  localparam logic [16:0] RFW  = 17'h00008;
  localparam logic [16:0] DST  = 17'h00004;
  localparam logic [16:0] RD2  = 17'h00002;
  localparam logic [16:0] DONE = 17'h00001;
  localparam logic [16:0] Z    = 17'h00000;
  localparam logic [16:0] FD   = REQ | IRW;
  localparam logic [16:0] WB   = RFW | PCW | DONE;
  localparam logic [5:0]  JUNK = 6'b111111;

  function automatic logic [16:0] pcs(input logic [1:0] v);
    return {5'b0, v, 10'b0};
  endfunction

  function automatic logic [16:0] alu(input logic [2:0] v);
    return {7'b0, v, 7'b0};
  endfunction

  function automatic logic [16:0] rfin(input logic [1:0] v);
    return {11'b0, v, 4'b0};
  endfunction

  function automatic logic [16:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.IR_write, bus.PC_write,
            bus.PC_src, bus.ALU_op, bus.ALU_src, bus.RF_in_sel, bus.RF_write,
            bus.RF_dst_r2, bus.RF_rd2_rd, bus.instr_done};
  endfunction

  // Apply inputs for the current cycle; the opcode bus carries junk unless ready
  task automatic drive(input logic rdy, input logic [5:0] op, input logic cond);
    bus.mem_ready    = rdy;
    bus.mem_rdata_op = rdy ? op : JUNK;
    bus.cond_flag    = cond;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 6'b000000, 1'b0);
    checks++;
    if (outs() !== Z) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", outs(), Z);
    end
    drive(1'b1, 6'b000011, 1'b1);
    checks++;
    if (outs() !== Z) begin
      errors++; $display("FAIL reset_ready got=%h exp=%h", outs(), Z);
    end
    @(negedge clk);
    checks++;
    if (outs() !== Z) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", outs(), Z);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_types();
    logic [5:0]  ops [3];
    logic [16:0] e [3][4];
    ops[0] = 6'b000011; ops[1] = 6'b001101; ops[2] = 6'b100010;
    e[0] = '{FD, Z, alu(3'd3),        WB};
    e[1] = '{FD, Z, alu(3'd5) | ASRC, WB};
    e[2] = '{FD, Z, Z,                WB | rfin(2'b10)};
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, ops[i], 1'b0);
        checks++;
        if (outs() !== e[i][c]) begin
          errors++; $display("FAIL alu_i%0d_c%0d got=%h exp=%h", i, c + 1, outs(), e[i][c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jumps();
    logic [5:0]  ops [3];
    logic        cnd [3];
    logic [16:0] e [3][3];
    ops[0] = 6'b111000; cnd[0] = 1'b1;
    ops[1] = 6'b110000; cnd[1] = 1'b1;
    ops[2] = 6'b110000; cnd[2] = 1'b0;
    e[0] = '{FD, Z, PCW | pcs(2'b10) | DONE};
    e[1] = '{FD, Z, PCW | pcs(2'b01) | DONE};
    e[2] = '{FD, Z, PCW | DONE};
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, ops[i], cnd[i]);
        checks++;
        if (outs() !== e[i][c]) begin
          errors++; $display("FAIL jump_i%0d_c%0d got=%h exp=%h", i, c + 1, outs(), e[i][c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_memory();
    logic [5:0]  ops [3];
    int          len [3];
    logic        r [3][7];
    logic [16:0] e [3][7];
    logic [16:0] mw;
    mw = REQ | ASEL | ASRC;
    ops[0] = 6'b101001; len[0] = 4;
    ops[1] = 6'b101000; len[1] = 7;
    ops[2] = 6'b101111; len[2] = 4;
    r[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    r[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    r[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e[0] = '{FD, RD2, ASRC, mw | WE | RD2 | PCW | DONE, Z, Z, Z};
    e[1] = '{FD, Z, ASRC, mw, mw, mw, WB | rfin(2'b01) | DST};
    e[2] = '{FD, Z, ASRC, mw | PCW | DONE, Z, Z, Z};
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < len[i]; c++) begin
        drive(r[i][c], ops[i], 1'b0);
        checks++;
        if (outs() !== e[i][c]) begin
          errors++; $display("FAIL mem_i%0d_c%0d got=%h exp=%h", i, c + 1, outs(), e[i][c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_nop_and_fetch_wait();
    logic [5:0]  ops [2];
    int          len [2];
    logic        r [2][5];
    logic [16:0] e [2][5];
    ops[0] = 6'b010000; len[0] = 3;
    ops[1] = 6'b000001; len[1] = 5;
    r[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    r[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    e[0] = '{FD, Z, PCW | DONE, Z, Z};
    e[1] = '{REQ, FD, Z, alu(3'd1), WB};
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < len[i]; c++) begin
        drive(r[i][c], ops[i], 1'b1);
        checks++;
        if (outs() !== e[i][c]) begin
          errors++; $display("FAIL nopw_i%0d_c%0d got=%h exp=%h", i, c + 1, outs(), e[i][c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_in_mem();
    logic [16:0] e [4];
    logic [16:0] tail [4];
    e    = '{FD, Z, ASRC, REQ | ASEL | ASRC};
    tail = '{FD, Z, alu(3'd2), WB};
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 6'b101000, 1'b0);
      checks++;
      if (outs() !== e[c]) begin
        errors++; $display("FAIL rmem_c%0d got=%h exp=%h", c + 1, outs(), e[c]);
      end
      if (c < 3) @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== Z) begin
      errors++; $display("FAIL rmem_abort got=%h exp=%h", outs(), Z);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== Z) begin
      errors++; $display("FAIL rmem_held got=%h exp=%h", outs(), Z);
    end
    rst = 1'b0;
    drive(1'b0, 6'b000010, 1'b0);
    checks++;
    if (outs() !== REQ) begin
      errors++; $display("FAIL rmem_refetch got=%h exp=%h", outs(), REQ);
    end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 6'b000010, 1'b0);
      checks++;
      if (outs() !== tail[c]) begin
        errors++; $display("FAIL rmem_next_c%0d got=%h exp=%h", c + 1, outs(), tail[c]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata_op = '0;
    bus.cond_flag    = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_types();
    test_jumps();
    test_memory();
    test_nop_and_fetch_wait();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 mem_rdata_op  input  6  opcode bits of the memory read data; valid when mem_ready=1.
REQ-004 cond_flag  input  1  branch condition from the ALU, sampled in EXECUTE.
REQ-005 mem_ready  input  1  memory completes the current request this cycle.
REQ-006 mem_req  output  1  memory access request; held until mem_ready.
REQ-007 mem_we  output  1  write strobe, qualified by mem_req.
REQ-008 mem_addr_sel  output  1  address source: 0 = PC, 1 = ALU result.
REQ-009 IR_write  output  1  load the instruction register.
REQ-010 PC_write  output  1  load the PC.
REQ-011 PC_src  output  2  next-PC source: 00 = plus1, 01 = offset, 10 = const.
REQ-012 ALU_op  output  3  ALU function.
REQ-013 ALU_src  output  1  ALU second operand: 0 = register, 1 = constant.
REQ-014 RF_in_sel  output  2  register-file write data: 00 = ALU, 01 = memory, 10 = shifter.
REQ-015 RF_write  output  1  register-file write enable.
REQ-016 RF_dst_r2  output  1  write destination is the r2 field.
REQ-017 RF_rd2_rd  output  1  register read port 2 is addressed by the rd field.
REQ-018 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK; outputs are combinational from the state and an internal 6-bit opcode register (op_q); outputs not listed for a state are 0.
REQ-020 FETCH: mem_req=1, mem_addr_sel=0; stays in FETCH while mem_ready=0.
REQ-021 FETCH with mem_ready=1: IR_write=1, op_q<=mem_rdata_op, next state DECODE.
REQ-022 DECODE: one cycle, no side effects; RF_rd2_rd=1 if op_q is STM; next state EXECUTE.
REQ-023 EXECUTE, ALU_op/ALU_src:
- Register type: ALU_op=op_q[2:0], ALU_src=0.
- Immediate type: ALU_op=op_q[2:0], ALU_src=1.
- Memory type: ALU_src=1, ALU_op=ADD constant.
REQ-024 EXECUTE, next state:
- Register, immediate or shift type: WRITEBACK.
- Memory type: MEM.
REQ-025 EXECUTE, conditional jump: PC_write=1, PC_src=01 if cond_flag else 00, instr_done=1, next state FETCH.
REQ-026 EXECUTE, non-conditional jump: PC_write=1, PC_src=10, instr_done=1, next state FETCH.
REQ-027 MEM: mem_req=1, mem_addr_sel=1, ALU_src=1, mem_we=1 for STM, RF_rd2_rd=1 for STM; stays in MEM while mem_ready=0.
REQ-028 MEM with mem_ready=1, STM: PC_write=1, PC_src=00, instr_done=1, next state FETCH.
REQ-029 MEM with mem_ready=1, LDM: next state WRITEBACK; the memory-type opcode with any other function code is treated as STM-less no-op and goes to FETCH with PC+1 and instr_done.
REQ-030 WRITEBACK: RF_write=1, PC_write=1, PC_src=00, instr_done=1, next state FETCH.
REQ-031 WRITEBACK, RF_in_sel/RF_dst_r2: 10 for shift type, 01 with RF_dst_r2=1 for LDM, 00 otherwise.
REQ-032 An opcode matching no type SHALL execute as a no-op: EXECUTE asserts PC_write, PC_src=00, instr_done; next state FETCH.
REQ-033 Decode priority SHALL be non-conditional jump, conditional jump, memory, shift, immediate, register, so that overlapping prefixes resolve deterministically.
REQ-034 Latency with zero-wait memory (mem_ready=1 on request):
- Jumps: 3 cycles.
- Register, immediate, shift and STM: 4 cycles.
- LDM: 5 cycles.
- Each memory wait cycle adds 1.
REQ-035 PC_write SHALL assert exactly once per instruction, and IR_write exactly once per instruction.

Reset
REQ-036 While rst=1: state=FETCH, op_q=0, and all outputs SHALL be forced to 0, including mem_req.
REQ-037 When rst asserts mid-instruction (including while waiting in MEM), the access SHALL be abandoned with no RF_write or PC_write; after release, fetch restarts in FETCH on the next edge.

Structure
REQ-038 Type-field opcode constants, STM_FN/LDM_FN, the state enum, and the PC_src/RF_in_sel encodings SHALL live in the shared defines package.
REQ-039 The opcode classifier SHALL be one combinational sub-module, opcode_decoder (op_q in, one-hot class out); the FSM stays in multi_cycle_controller.

Verification
REQ-040 Register-type op, mem_ready always 1: IR_write at cycle 1; RF_write, PC_write with PC_src=00 and instr_done at cycle 4.
REQ-041 LDM with 2 wait cycles in MEM: mem_req and mem_addr_sel=1 held 3 cycles; WRITEBACK has RF_in_sel=01, RF_dst_r2=1; total 7 cycles.
REQ-042 Conditional jump with cond_flag=1, then cond_flag=0: PC_src=01, then 00; both finish in 3 cycles with no RF_write.
REQ-043 STM: mem_we=1 and RF_rd2_rd=1 in MEM; no RF_write; instr_done at cycle 4.
REQ-044 rst pulsed while in MEM with mem_ready=0: all outputs 0 immediately; next fetch begins after release; no PC_write is seen for the aborted instruction.
